// File: rtl/shared_alu_arb.sv
// Four-requester round-robin arbiter in front of one shared ALU.
// The ALU does add, compare, and a WIDTH-cycle shift-add multiply.
module shared_alu_arb #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [7:0]           op,
  input  logic [4*WIDTH-1:0]   X,
  input  logic [4*WIDTH-1:0]   Y,
  output logic [3:0]           ack,
  output logic [2*WIDTH-1:0]   result,
  output logic [2:0]           flags,
  output logic                 valid,
  output logic                 err,
  output logic                 busy,
  output logic [1:0]           grant_id
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               state;
  logic [1:0]           last_grant;
  logic [1:0]           op_l;
  logic [2*WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mul_next;
  logic [1:0]           pick;
  logic                 found;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    logic [1:0] idx;
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign mul_next = acc + (b_reg[0] ? a_reg : '0);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      grant_id   <= 2'd0;
      op_l       <= 2'd0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      result     <= '0;
      flags      <= 3'b000;
      valid      <= 1'b0;
      ack        <= 4'b0000;
      err        <= 1'b0;
    end else begin
      valid <= 1'b0;
      ack   <= 4'b0000;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= pick;
            op_l     <= op[2*pick +: 2];
            a_reg    <= {{WIDTH{1'b0}}, X[pick*WIDTH +: WIDTH]};
            b_reg    <= Y[pick*WIDTH +: WIDTH];
            acc      <= '0;
            cnt      <= CW'(WIDTH - 1);
            state    <= EXEC;
          end
        end
        EXEC: begin
          case (op_l)
            2'b00: result <= {{(WIDTH-1){1'b0}},
                              ({1'b0, a_reg[WIDTH-1:0]} + {1'b0, b_reg})};
            2'b10: begin
              result <= '0;
              flags  <= {a_reg[WIDTH-1:0] > b_reg,
                         a_reg[WIDTH-1:0] < b_reg,
                         a_reg[WIDTH-1:0] == b_reg};
            end
            2'b11: begin
              result <= '0;
              flags  <= 3'b000;
            end
            default: begin
              acc   <= mul_next;
              a_reg <= a_reg << 1;
              b_reg <= b_reg >> 1;
              if (cnt == '0) result <= mul_next;
              else           cnt    <= cnt - 1'b1;
            end
          endcase
          // Multiply finishes on the counter's terminal count; all others after one cycle.
          if (op_l != 2'b01 || cnt == '0) begin
            state <= DONE;
            valid <= 1'b1;
            ack   <= 4'b0001 << grant_id;
            err   <= (op_l == 2'b11);
          end
        end
        DONE: begin
          last_grant <= grant_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
